// File: rtl/mem_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous memory.
// One access in flight at a time; read data is returned with a done pulse.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]            r_state;
    logic                  r_last;
    logic                  r_sel;
    logic [1:0]            r_gnt;
    logic [1:0]            r_done;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data_in;

    logic                  w_any;
    logic                  w_win;
    logic                  w_we;

    // On a tie the requester that was not granted last wins.
    assign w_any = req0 | req1;
    assign w_win = (req0 & req1) ? ~r_last : req1;
    assign w_we  = w_win ? we1 : we0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last        <= 1'b1;
            r_sel         <= 1'b0;
            r_gnt         <= '0;
            r_done        <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel         <= w_win;
                        r_last        <= w_win;
                        r_gnt[w_win]  <= 1'b1;
                        r_mem_addr    <= w_win ? addr1 : addr0;
                        r_mem_data_in <= w_win ? wdata1 : wdata0;
                        r_mem_write   <= w_we;
                        r_mem_read    <= ~w_we;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    // A write has landed at this edge; a read still needs a capture cycle.
                    if (r_mem_write) begin
                        r_done[r_sel] <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (r_sel) r_rdata1 <= mem_data_out;
                    else       r_rdata0 <= mem_data_out;
                    r_done[r_sel] <= 1'b1;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt0        = r_gnt[0];
    assign gnt1        = r_gnt[1];
    assign done0       = r_done[0];
    assign done1       = r_done[1];
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks of mem_arbiter against a behavioural 32x8 memory.
// Outputs are sampled 1 time unit after the rising edge.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] rdata0, rdata1;
    logic       mem_read, mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    logic [7:0] mem [0:31];
    logic [7:0] ref_mem [0:31];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write lands at the edge, read data appears after the edge.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read)  mem_data_out  <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({gnt0, gnt1, done0, done1, mem_read, mem_write,
                    mem_addr, mem_data_in, rdata0, rdata1});
    endfunction

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk(tag, all_outs(), 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    bit         pend0, pend1, pend_rd0, pend_rd1;
    logic [7:0] exp_rd0, exp_rd1;
    int         n_excl, n_grants;

    initial begin
        rst_n = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset asserted mid-cycle: outputs clear without a clock edge.
        repeat (2) @(posedge clk);
        pulse_reset("reset_async_clear");
        $display("[TB] reset applied");

        // Single write then read by requester 0.
        req0 = 1; we0 = 1; addr0 = 5'h03; wdata0 = 8'hA5;
        tick();
        chk("wr_gnt", 64'({gnt0, gnt1, done0}), 64'b100);
        chk("wr_strobes", 64'({mem_write, mem_read}), 64'b10);
        chk("wr_addr_data", 64'({mem_addr, mem_data_in}), 64'({5'h03, 8'hA5}));
        req0 = 0;
        tick();
        chk("wr_done", 64'({gnt0, done0, mem_write}), 64'b010);
        tick();
        chk("wr_done_pulse_end", 64'(done0), 64'h0);
        $display("[TB] req0 write addr 03 = a5");

        req0 = 1; we0 = 0; addr0 = 5'h03;
        tick();
        chk("rd_gnt_strobes", 64'({gnt0, mem_read, mem_write}), 64'b110);
        req0 = 0;
        tick();
        chk("rd_no_early_done", 64'({done0, mem_read}), 64'b00);
        tick();
        chk("rd_done", 64'(done0), 64'h1);
        chk("rd_data", 64'(rdata0), 64'hA5);
        tick();
        chk("rd_hold", 64'({done0, rdata0}), 64'({1'b0, 8'hA5}));
        $display("[TB] req0 read addr 03 -> %0h", rdata0);

        // Simultaneous writes from reset: requester 0 wins the first tie.
        pulse_reset("reset2_clear");
        req0 = 1; we0 = 1; addr0 = 5'h01; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 5'h02; wdata1 = 8'h22;
        tick();
        chk("tie_gnt0", 64'({gnt0, gnt1, mem_addr}), 64'({2'b10, 5'h01}));
        req0 = 0;
        tick();
        chk("tie_done0", 64'({done0, gnt1}), 64'b10);
        tick();
        chk("tie_gnt1", 64'({gnt0, gnt1, mem_write, mem_addr, mem_data_in}),
            64'({3'b011, 5'h02, 8'h22}));
        req1 = 0;
        tick();
        chk("tie_done1", 64'({done0, done1}), 64'b01);
        tick();
        $display("[TB] tie writes addr 01 = 11, addr 02 = 22");
        req1 = 1; we1 = 0; addr1 = 5'h01;
        tick();
        chk("r1_gnt", 64'(gnt1), 64'h1);
        req1 = 0;
        tick();
        tick();
        chk("r1_done", 64'({done1, rdata1, rdata0}), 64'({1'b1, 8'h11, 8'h00}));
        $display("[TB] req1 read addr 01 -> %0h", rdata1);
        tick();

        // Round robin: both requesters read continuously, 6 grants.
        req0 = 1; we0 = 0; addr0 = 5'h02;
        req1 = 1; we1 = 0; addr1 = 5'h01;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr_gnt_%0d", k), 64'({gnt0, gnt1}),
                (k % 2 == 0) ? 64'b10 : 64'b01);
            if (k == 5) begin req0 = 0; req1 = 0; end
            tick();
            chk($sformatf("rr_gap_%0d", k), 64'({gnt0, gnt1, done0, done1}), 64'h0);
            tick();
            if (k % 2 == 0)
                chk($sformatf("rr_done_%0d", k), 64'({done0, done1, rdata0}), 64'({2'b10, 8'h22}));
            else
                chk($sformatf("rr_done_%0d", k), 64'({done0, done1, rdata1}), 64'({2'b01, 8'h11}));
            $display("[TB] rr grant %0d to requester %0d", k, k % 2);
        end
        tick();

        // Random traffic on both requesters against a reference memory.
        for (int a = 0; a < 32; a++) ref_mem[a] = mem[a];
        pend0 = 0; pend1 = 0; n_excl = 0; n_grants = 0;
        for (int c = 0; c < 1010; c++) begin
            if (c < 1000 && !req0 && $urandom_range(1, 0) == 1) begin
                req0 = 1; we0 = 1'($urandom); addr0 = 5'($urandom); wdata0 = 8'($urandom);
            end
            if (c < 1000 && !req1 && $urandom_range(1, 0) == 1) begin
                req1 = 1; we1 = 1'($urandom); addr1 = 5'($urandom); wdata1 = 8'($urandom);
            end
            tick();
            if (mem_read && mem_write) n_excl++;
            if ((gnt0 && gnt1) || (done0 && done1)) n_excl++;
            if (done0) begin
                chk("rand_done0_pending", 64'(pend0), 64'h1);
                if (pend_rd0) chk("rand_rdata0", 64'(rdata0), 64'(exp_rd0));
                $display("[TB] rand req0 %s done rdata0=%0h", pend_rd0 ? "read" : "write", rdata0);
                pend0 = 0;
            end
            if (done1) begin
                chk("rand_done1_pending", 64'(pend1), 64'h1);
                if (pend_rd1) chk("rand_rdata1", 64'(rdata1), 64'(exp_rd1));
                $display("[TB] rand req1 %s done rdata1=%0h", pend_rd1 ? "read" : "write", rdata1);
                pend1 = 0;
            end
            if (gnt0) begin
                chk("rand_gnt0_cmd", 64'({mem_write, mem_read, mem_addr, we0 ? mem_data_in : 8'h00}),
                    64'({we0, ~we0, addr0, we0 ? wdata0 : 8'h00}));
                if (we0) ref_mem[addr0] = wdata0;
                else exp_rd0 = ref_mem[addr0];
                pend0 = 1; pend_rd0 = !we0; req0 = 0; n_grants++;
            end
            if (gnt1) begin
                chk("rand_gnt1_cmd", 64'({mem_write, mem_read, mem_addr, we1 ? mem_data_in : 8'h00}),
                    64'({we1, ~we1, addr1, we1 ? wdata1 : 8'h00}));
                if (we1) ref_mem[addr1] = wdata1;
                else exp_rd1 = ref_mem[addr1];
                pend1 = 1; pend_rd1 = !we1; req1 = 0; n_grants++;
            end
        end
        req0 = 0; req1 = 0;
        chk("rand_exclusivity", 64'(n_excl), 64'h0);
        chk("rand_all_completed", 64'({pend0, pend1}), 64'h0);
        chk("rand_progress", 64'(n_grants > 100), 64'h1);

        // Reset during CAPTURE abandons the read; memory keeps its content.
        pulse_reset("reset3_clear");
        req0 = 1; we0 = 1; addr0 = 5'h07; wdata0 = 8'h5C;
        tick();
        req0 = 0;
        tick();
        chk("c_wr_done", 64'(done0), 64'h1);
        tick();
        req1 = 1; we1 = 0; addr1 = 5'h07;
        tick();
        chk("c_rd_gnt", 64'(gnt1), 64'h1);
        req1 = 0;
        tick();
        #2 rst_n = 1'b0;
        #1 chk("c_reset_clear", all_outs(), 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("c_no_done_a", 64'({done0, done1, rdata1}), 64'h0);
        tick();
        chk("c_no_done_b", 64'({done0, done1, rdata1}), 64'h0);
        $display("[TB] read of addr 07 abandoned by reset");
        req1 = 1; we1 = 0; addr1 = 5'h07;
        tick();
        chk("c_rd2_gnt", 64'(gnt1), 64'h1);
        req1 = 0;
        tick();
        tick();
        chk("c_rd2_done", 64'({done1, rdata1}), 64'({1'b1, 8'h5C}));
        $display("[TB] req1 read addr 07 -> %0h", rdata1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
